// File: rtl/ip_pad_switch.sv
// Pad multiplexer that routes one of NUM_IP pad sources onto the chip pads and
// changes the source only through a blanked drain / switch / settle sequence.
module ip_pad_switch #(
    parameter int PAD_W   = 82,
    parameter int NUM_IP  = 6,
    parameter int GUARD   = 4,
    parameter int RST_SEL = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IP*PAD_W-1:0]  ip_o,
    input  logic [NUM_IP*PAD_W-1:0]  ip_oe,
    input  logic [2:0]               sel_req,
    input  logic                     sel_req_valid,
    output logic                     sel_req_ready,
    output logic [PAD_W-1:0]         io_pad_o,
    output logic [PAD_W-1:0]         io_pad_oe,
    output logic [2:0]               cur_sel,
    output logic                     busy,
    output logic                     switch_done,
    output logic                     sel_err
);

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2,
        SETTLE = 2'd3
    } state_t;

    localparam int              CNT_W      = 4;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(GUARD - 1);
    localparam logic [2:0]      SEL_RESET  = 3'(RST_SEL);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       sel_q, sel_nxt;
    logic [2:0]       tgt_q, tgt_nxt;
    logic             done_nxt, err_nxt;
    logic             pass_nxt;
    logic             accept, sel_legal;

    function automatic logic [PAD_W-1:0] pick(input logic [NUM_IP*PAD_W-1:0] bus,
                                              input logic [2:0] s);
        pick = bus[int'(s)*PAD_W +: PAD_W];
    endfunction

    assign sel_req_ready = (state == ACTIVE) && rst_n;
    assign accept        = sel_req_valid && sel_req_ready;
    assign sel_legal     = int'(sel_req) < NUM_IP;
    assign busy          = (state != ACTIVE);
    assign cur_sel       = sel_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel_q;
        tgt_nxt   = tgt_q;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        pass_nxt  = 1'b0;
        case (state)
            ACTIVE: begin
                pass_nxt = 1'b1;
                if (accept) begin
                    if (!sel_legal) begin
                        err_nxt = 1'b1;
                    end else if (sel_req == sel_q) begin
                        done_nxt = 1'b1;
                    end else begin
                        // Blank from the accepting edge onward so no mixed IP reaches the pads.
                        state_nxt = DRAIN;
                        cnt_nxt   = CNT_RELOAD;
                        tgt_nxt   = sel_req;
                        pass_nxt  = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (cnt == '0) begin
                    state_nxt = SWITCH;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            SWITCH: begin
                state_nxt = SETTLE;
                sel_nxt   = tgt_q;
                cnt_nxt   = CNT_RELOAD;
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = ACTIVE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ACTIVE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ACTIVE;
            cnt         <= '0;
            sel_q       <= SEL_RESET;
            tgt_q       <= SEL_RESET;
            switch_done <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sel_q       <= sel_nxt;
            tgt_q       <= tgt_nxt;
            switch_done <= done_nxt;
            sel_err     <= err_nxt;
        end
    end

    // Pad register stage: the selected slice, or all-zero while blanked or in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            io_pad_o  <= '0;
            io_pad_oe <= '0;
        end else if (pass_nxt) begin
            io_pad_o  <= pick(ip_o, sel_q);
            io_pad_oe <= pick(ip_oe, sel_q);
        end else begin
            io_pad_o  <= '0;
            io_pad_oe <= '0;
        end
    end

endmodule

// File: tb/tb_ip_pad_switch.sv
// Directed bench for ip_pad_switch: expectations are queued before each clock
// edge and popped and compared on the following falling edge.
module tb_ip_pad_switch;

    localparam int PAD_W  = 82;
    localparam int NUM_IP = 6;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_IP*PAD_W-1:0] ip_o, ip_oe;
    logic [2:0]              sel_req;
    logic                    sel_req_valid;
    logic                    sel_req_ready;
    logic [PAD_W-1:0]        io_pad_o, io_pad_oe;
    logic [2:0]              cur_sel;
    logic                    busy, switch_done, sel_err;

    logic [PAD_W-1:0] d  [NUM_IP];
    logic [PAD_W-1:0] oe [NUM_IP];

    typedef struct {
        logic [PAD_W-1:0] po;
        logic [PAD_W-1:0] poe;
        logic [2:0]       cs;
        logic             bsy;
        logic             dn;
        logic             er;
        logic             rdy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ip_pad_switch #(.PAD_W(PAD_W), .NUM_IP(NUM_IP), .GUARD(4), .RST_SEL(1)) dut (
        .clk(clk), .rst_n(rst_n), .ip_o(ip_o), .ip_oe(ip_oe),
        .sel_req(sel_req), .sel_req_valid(sel_req_valid), .sel_req_ready(sel_req_ready),
        .io_pad_o(io_pad_o), .io_pad_oe(io_pad_oe), .cur_sel(cur_sel),
        .busy(busy), .switch_done(switch_done), .sel_err(sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < NUM_IP; k++) begin : g_pack
        assign ip_o[k*PAD_W +: PAD_W]  = d[k];
        assign ip_oe[k*PAD_W +: PAD_W] = oe[k];
    end

    function automatic logic [PAD_W-1:0] pat(input logic [7:0] b);
        logic [PAD_W-1:0] r;
        for (int i = 0; i < PAD_W; i++) r[i] = b[i % 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [PAD_W-1:0] obs, input logic [PAD_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue the expected post-edge state, advance one cycle, then compare.
    task automatic step_expect(input logic [PAD_W-1:0] po, input logic [PAD_W-1:0] poe,
                               input logic [2:0] cs, input logic bsy, input logic dn,
                               input logic er, input logic rdy);
        exp_t e;
        e = '{po: po, poe: poe, cs: cs, bsy: bsy, dn: dn, er: er, rdy: rdy};
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk("io_pad_o", io_pad_o, e.po);
        chk("io_pad_oe", io_pad_oe, e.poe);
        chk("cur_sel", PAD_W'(cur_sel), PAD_W'(e.cs));
        chk("busy", PAD_W'(busy), PAD_W'(e.bsy));
        chk("switch_done", PAD_W'(switch_done), PAD_W'(e.dn));
        chk("sel_err", PAD_W'(sel_err), PAD_W'(e.er));
        chk("sel_req_ready", PAD_W'(sel_req_ready), PAD_W'(e.rdy));
    endtask

    // Edges E1..E9 (and E10 unless the next request is already pending) of a switch.
    task automatic switch_body(input int from, input int to, input bit hold);
        for (int i = 1; i <= 4; i++) begin
            d[from] = pat(8'(i * 17));
            d[to]   = pat(8'(i * 29));
            oe[to]  = pat(8'(i * 7));
            step_expect('0, '0, 3'(from), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 5; i <= 8; i++) begin
            d[from] = pat(8'(i * 13));
            d[to]   = pat(8'(i * 31));
            step_expect('0, '0, 3'(to), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        d[to]  = pat(8'(8'h60 + to));
        oe[to] = pat(8'(8'hF0 + to));
        step_expect('0, '0, 3'(to), 1'b0, 1'b1, 1'b0, 1'b1);
        if (!hold) step_expect(d[to], oe[to], 3'(to), 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n         = 1'b0;
        sel_req       = 3'd0;
        sel_req_valid = 1'b0;
        for (int k = 0; k < NUM_IP; k++) begin
            d[k]  = pat(8'(8'h10 + k));
            oe[k] = pat(8'(8'h3C ^ k));
        end
        d[1]  = pat(8'hA5);
        oe[1] = '1;

        // Reset held for 100 cycles: everything quiet, not ready.
        for (int i = 0; i < 100; i++)
            step_expect('0, '0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Release: RST_SEL slice appears after the first edge.
        rst_n = 1'b1;
        step_expect(pat(8'hA5), '1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        d[1] = pat(8'h5A);
        step_expect(pat(8'h5A), '1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Illegal select: error pulse, stream continues.
        sel_req = 3'd6; sel_req_valid = 1'b1; d[1] = pat(8'hC3);
        step_expect(pat(8'hC3), '1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        sel_req_valid = 1'b0; d[1] = pat(8'h96);
        step_expect(pat(8'h96), '1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Same select: done pulse, no busy, no oe gap.
        sel_req = 3'd1; sel_req_valid = 1'b1; d[1] = pat(8'h33);
        step_expect(pat(8'h33), '1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        sel_req_valid = 1'b0;
        step_expect(pat(8'h33), '1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Switch 1 -> 3.
        sel_req = 3'd3; sel_req_valid = 1'b1;
        step_expect('0, '0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        sel_req_valid = 1'b0;
        switch_body(1, 3, 1'b0);

        // Switch 3 -> 0 with a second request (5) held valid throughout.
        sel_req = 3'd0; sel_req_valid = 1'b1;
        step_expect('0, '0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        sel_req = 3'd5;
        switch_body(3, 0, 1'b1);
        step_expect('0, '0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        sel_req_valid = 1'b0;
        switch_body(0, 5, 1'b0);

        // Reset at E3 of a 5 -> 2 switch abandons it.
        sel_req = 3'd2; sel_req_valid = 1'b1;
        step_expect('0, '0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        sel_req_valid = 1'b0;
        step_expect('0, '0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step_expect('0, '0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step_expect('0, '0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        d[1] = pat(8'h77); oe[1] = pat(8'hE1);
        for (int i = 0; i < 12; i++)
            step_expect(pat(8'h77), pat(8'hE1), 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ip_pad_switch.md
IP_PAD_SWITCH -- requirements
Module: ip_pad_switch

Interface
REQ-001 Parameter PAD_W, default 82: width of the pad output and output-enable buses.
REQ-002 Parameter NUM_IP, default 6: number of IP sources; legal selects are 0..NUM_IP-1.
REQ-003 Parameter GUARD, default 4: number of cycles in each of the drain and settle phases; legal range 1..15.
REQ-004 Parameter RST_SEL, default 1: IP select loaded at reset.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 ip_o  in  NUM_IP*PAD_W  flattened per-IP pad data; IP k occupies bits [k*PAD_W +: PAD_W].
REQ-008 ip_oe  in  NUM_IP*PAD_W  flattened per-IP pad output enables, same packing as ip_o.
REQ-009 sel_req  in  3  requested IP select.
REQ-010 sel_req_valid  in  1  request qualifier.
REQ-011 sel_req_ready  out  1  request acceptance; high only in ACTIVE with rst_n high.
REQ-012 io_pad_o  out  PAD_W  registered pad data toward asic_top io_pad_i.
REQ-013 io_pad_oe  out  PAD_W  registered pad output enables.
REQ-014 cur_sel  out  3  currently routed IP select.
REQ-015 busy  out  1  high in DRAIN, SWITCH and SETTLE.
REQ-016 switch_done  out  1  one-cycle pulse on completion of a switch or same-select accept.
REQ-017 sel_err  out  1  one-cycle pulse on rejection of an illegal select.

Function
REQ-018 The FSM SHALL have the states ACTIVE, DRAIN, SWITCH and SETTLE.
REQ-019 A request SHALL be accepted on a rising edge where sel_req_valid and sel_req_ready are both high; sel_req is captured at that edge.
REQ-020 In ACTIVE, io_pad_o and io_pad_oe SHALL register the cur_sel slice of ip_o/ip_oe, giving one cycle of latency.
REQ-021 Accepting sel_req >= NUM_IP SHALL pulse sel_err in the following cycle and leave state and cur_sel unchanged.
REQ-022 Accepting sel_req == cur_sel SHALL pulse switch_done in the following cycle, stay in ACTIVE and cause no output gap.
REQ-023 Accepting any other legal select (edge E0) SHALL move to DRAIN with the guard counter set to GUARD-1.
REQ-024 From edge E0, io_pad_oe and io_pad_o SHALL be forced to all-zero until the first output update after ACTIVE is re-entered.
REQ-025 DRAIN SHALL decrement the guard counter each cycle and go to SWITCH at the edge where the counter is 0, which is edge E(GUARD).
REQ-026 SWITCH SHALL last one cycle; at edge E(GUARD+1) cur_sel takes the target, the state goes to SETTLE and the counter reloads GUARD-1.
REQ-027 SETTLE SHALL count down the same way and go to ACTIVE at edge E(2*GUARD+1).
REQ-028 switch_done SHALL be high for the cycle following edge E(2*GUARD+1).
REQ-029 The first new-IP output SHALL appear after edge E(2*GUARD+2).
REQ-030 sel_req_valid SHALL be ignored while busy; nothing is queued, and the requester holds valid until ready.
REQ-031 switch_done and sel_err SHALL never be high in the same cycle.
REQ-032 Changes on ip_o/ip_oe during DRAIN, SWITCH or SETTLE SHALL have no effect on the outputs.

Reset
REQ-033 While rst_n is low at a rising edge, the block SHALL set state to ACTIVE, cur_sel to RST_SEL, counter to 0, and io_pad_o, io_pad_oe, switch_done, sel_err and busy to 0.
REQ-034 sel_req_ready SHALL be 0 while rst_n is low.
REQ-035 A reset mid-switch SHALL abandon the switch and emit no switch_done.
REQ-036 The first edge after rst_n rises SHALL register the RST_SEL slice onto the outputs.

Verification
REQ-037 Reset then pass: hold rst_n low 100 cycles, drive ip_o slice1 = all 'hA5 pattern with ip_oe slice1 all-ones -> outputs zero during reset, then the pattern and all-ones one edge after release, cur_sel=1.
REQ-038 Switch 1->3 with GUARD=4, accepted at E0 -> io_pad_oe=0 from E0, cur_sel=3 at E5, busy high E0..E9, switch_done high the cycle after E9, slice3 data on the outputs after E10.
REQ-039 Illegal select sel_req=6 -> sel_err one cycle, cur_sel unchanged, output stream uninterrupted.
REQ-040 Same select sel_req=1 while cur_sel=1 -> switch_done one cycle, busy stays 0, no oe gap.
REQ-041 Second request held valid while busy -> ready=0 throughout; accepted on the first ACTIVE cycle after switch_done.
REQ-042 rst_n low at E3 of a switch -> next cycle cur_sel=RST_SEL, no switch_done, state ACTIVE.
